// File: rtl/construtor_caminho_pkg.sv
// Shared definitions for the path builder and the established-memory writer:
// FSM encoding and the field layout of an established-memory word.
`ifndef CONSTRUTOR_CAMINHO_PKG_SV
`define CONSTRUTOR_CAMINHO_PKG_SV

// Predecessor ("anterior") field of an established-memory word.
`define EST_ANTERIOR(word, aw) word[(aw)-1:0]

package construtor_caminho_pkg;

    typedef enum logic [2:0] {
        StOcioso,
        StLer,
        StEspera,
        StSaida,
        StPronto,
        StErro
    } estado_t;

    // The "estabelecido" flag sits in the word's most significant bit.
    function automatic int unsigned est_flag_bit(input int unsigned data_width);
        return data_width - 1;
    endfunction

endpackage

`endif

// File: rtl/construtor_caminho_pilha.sv
// LIFO holding the nodes of the walked path; top is combinational from the
// register array, so a pushed node is readable in the following cycle.
module pilha_caminho
#(
    parameter int unsigned ADDR_WIDTH = 6
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  one
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SpOne = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] mem_q [Depth];
    logic [ADDR_WIDTH:0]   sp_q;
    logic [ADDR_WIDTH-1:0] top_idx;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SpOne;
        end else if (pop) begin
            sp_q <= sp_q - SpOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[sp_q[ADDR_WIDTH-1:0]] <= push_data;
        end
    end

    // With sp at full depth the low bits wrap to 0, so top_idx still lands on the last entry.
    assign top_idx = sp_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (sp_q == '0);
    assign one     = (sp_q == SpOne);

endmodule

// File: rtl/construtor_caminho.sv
// Path builder: walks predecessor links from destino back to fonte, stacks
// the nodes, then streams them source-first with a valid/lido handshake.
module construtor_caminho
    import construtor_caminho_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  construir_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  est_rd_en_out,
    output logic [ADDR_WIDTH-1:0] est_rd_addr_out,
    input  logic [DATA_WIDTH-1:0] est_rd_data_in,
    output logic                  caminho_valid_out,
    output logic [ADDR_WIDTH-1:0] caminho_addr_out,
    output logic                  caminho_ultimo_out,
    input  logic                  lido_in,
    output logic                  caminho_pronto_out,
    output logic                  erro_out,
    output logic                  ocupado_out
);
    localparam int unsigned EstFlagBit = est_flag_bit(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] MaxLen = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] CntOne = (ADDR_WIDTH + 1)'(1);

    estado_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0] fonte_q, cur_q;
    logic [ADDR_WIDTH:0]   cnt_q;

    logic                  inicio, push, pop, clear;
    logic [ADDR_WIDTH-1:0] pilha_top;
    logic                  pilha_empty, pilha_one;
    logic                  est_flag;
    logic [ADDR_WIDTH-1:0] est_anterior;
    logic                  unused_est;

    assign est_flag     = est_rd_data_in[EstFlagBit];
    assign est_anterior = `EST_ANTERIOR(est_rd_data_in, ADDR_WIDTH);
    assign unused_est   = ^est_rd_data_in;

    assign inicio = (state_q == StOcioso) && construir_in;
    assign push   = (state_q == StEspera);
    assign pop    = (state_q == StSaida) && lido_in;
    assign clear  = inicio || (state_q == StErro);

    pilha_caminho #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pilha (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (cur_q),
        .top       (pilha_top),
        .empty     (pilha_empty),
        .one       (pilha_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOcioso;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fonte_q <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else if (inicio) begin
            fonte_q <= fonte_in;
            cur_q   <= destino_in;
            cnt_q   <= '0;
        end else if (state_q == StEspera) begin
            cnt_q <= cnt_q + CntOne;
            if (state_d == StLer) begin
                cur_q <= est_anterior;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOcioso: if (construir_in) state_d = StLer;
            StLer:    state_d = StEspera;
            StEspera: begin
                // Source match wins, so the source entry's own word is never inspected.
                if (cur_q == fonte_q) begin
                    state_d = StSaida;
                end else if (!est_flag) begin
                    state_d = StErro;
                end else if ((cnt_q + CntOne) == MaxLen) begin
                    state_d = StErro;
                end else begin
                    state_d = StLer;
                end
            end
            StSaida:  if (lido_in && pilha_one) state_d = StPronto;
            StPronto: state_d = StOcioso;
            StErro:   state_d = StOcioso;
            default:  state_d = StOcioso;
        endcase
    end

    always_comb begin
        est_rd_en_out      = (state_q == StLer);
        est_rd_addr_out    = est_rd_en_out ? cur_q : '0;
        caminho_valid_out  = (state_q == StSaida) && !pilha_empty;
        caminho_addr_out   = caminho_valid_out ? pilha_top : '0;
        caminho_ultimo_out = caminho_valid_out && pilha_one;
        caminho_pronto_out = (state_q == StPronto);
        erro_out           = (state_q == StErro);
        ocupado_out        = (state_q != StOcioso);
    end

endmodule

// File: tb/tb_construtor_caminho.sv
// Randomised self-checking bench for construtor_caminho against a
// path-walking reference model and a 1-cycle-latency memory model.
module tb_construtor_caminho;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       construir = 1'b0;
    logic [5:0] fonte = '0;
    logic [5:0] destino = '0;
    logic       est_rd_en;
    logic [5:0] est_rd_addr;
    logic [7:0] est_rd_data = '0;
    logic       valid;
    logic [5:0] caddr;
    logic       ultimo;
    logic       lido = 1'b1;
    logic       pronto;
    logic       erro;
    logic       ocupado;

    logic [7:0] mem [64];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    construtor_caminho #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .construir_in       (construir),
        .fonte_in           (fonte),
        .destino_in         (destino),
        .est_rd_en_out      (est_rd_en),
        .est_rd_addr_out    (est_rd_addr),
        .est_rd_data_in     (est_rd_data),
        .caminho_valid_out  (valid),
        .caminho_addr_out   (caddr),
        .caminho_ultimo_out (ultimo),
        .lido_in            (lido),
        .caminho_pronto_out (pronto),
        .erro_out           (erro),
        .ocupado_out        (ocupado)
    );

    // Read data is only meaningful the cycle after a read; garbage otherwise.
    always @(posedge clk) begin
        if (est_rd_en) est_rd_data <= mem[est_rd_addr];
        else           est_rd_data <= 8'($urandom);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_case(input logic [5:0] f, input logic [5:0] d, input int stall_at,
                            input int stall_len, input bit poke, input bit rnd_lido);
        logic [5:0] walk[$];
        logic [5:0] cur;
        bit         err;
        int         n, reads, idx, stalled, budget;

        // Reference: follow predecessors from d until f, a cleared flag, or 64 nodes.
        walk = {};
        cur  = d;
        err  = 1'b0;
        forever begin
            walk.push_back(cur);
            if (cur == f) break;
            if (!mem[cur][7]) begin err = 1'b1; break; end
            if (walk.size() == 64) begin err = 1'b1; break; end
            cur = mem[cur][5:0];
        end
        n = walk.size();

        @(negedge clk);
        fonte = f; destino = d; construir = 1'b1; lido = 1'b1;
        @(posedge clk); #1;
        construir = 1'b0;
        fonte = 6'($urandom); destino = 6'($urandom);
        reads = 0;
        for (int c = 0; c < 2 * n; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            check_eq("walk_flags", {28'd0, valid, erro, pronto, ocupado}, 32'b0001);
            if (est_rd_en) begin
                if (reads < n) check_eq("rd_addr", {26'd0, est_rd_addr}, {26'd0, walk[reads]});
                else           check_eq("rd_extra", reads + 1, n);
                reads++;
            end
        end
        @(posedge clk); #1;
        check_eq("reads", reads, n);

        if (err) begin
            check_eq("erro_pulse", {28'd0, valid, erro, pronto, ocupado}, 32'b0101);
            @(posedge clk); #1;
            check_eq("erro_idle", {28'd0, valid, erro, pronto, ocupado}, 32'b0000);
        end else begin
            idx = 0;
            stalled = 0;
            budget = 20 * n + stall_len + 10;
            for (int t = 0; t < budget && idx < n; t++) begin
                if (t > 0) begin @(posedge clk); #1; end
                if (poke && t == 0) begin
                    construir = 1'b1; fonte = 6'($urandom); destino = 6'($urandom);
                end else begin
                    construir = 1'b0;
                end
                if (idx == stall_at && stalled < stall_len) begin
                    lido = 1'b0; stalled++;
                end else if (rnd_lido) begin
                    lido = 1'($urandom_range(0, 1));
                end else begin
                    lido = 1'b1;
                end
                check_eq("valid", {31'd0, valid}, 32'd1);
                check_eq("node", {26'd0, caddr}, {26'd0, walk[n-1-idx]});
                check_eq("ultimo", {31'd0, ultimo}, {31'd0, idx == n - 1});
                check_eq("no_pulse", {30'd0, erro, pronto}, 32'd0);
                if (valid && lido) idx++;
            end
            if (idx < n) check_eq("stream_timeout", idx, n);
            @(posedge clk); #1;
            construir = 1'b0; lido = 1'b1;
            check_eq("pronto_pulse", {28'd0, valid, erro, pronto, ocupado}, 32'b0011);
            @(posedge clk); #1;
            check_eq("pronto_idle", {28'd0, valid, erro, pronto, ocupado}, 32'b0000);
        end
    endtask

    task automatic random_case();
        logic [5:0] nodes[64];
        logic [5:0] tmp;
        int         l, mode, j;
        for (int i = 0; i < 64; i++) nodes[i] = 6'(i);
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = nodes[i]; nodes[i] = nodes[j]; nodes[j] = tmp;
        end
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        l = $urandom_range(1, 8);
        mode = $urandom_range(0, 3);
        for (int i = 0; i < l - 1; i++) mem[nodes[i]] = {2'b10, nodes[i+1]};
        if (mode == 2 && l >= 2) mem[nodes[$urandom_range(0, l - 2)]][7] = 1'b0;
        if (mode == 3 && l >= 2) mem[nodes[l-2]] = {2'b10, nodes[0]};
        run_case(nodes[l-1], nodes[0], $urandom_range(0, l - 1), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic load_chain();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[5] = {2'b10, 6'd3};
        mem[3] = {2'b10, 6'd1};
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {14'd0, est_rd_en, est_rd_addr, valid, caddr, ultimo, pronto,
                                erro, ocupado}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_chain();
        run_case(6'd1, 6'd5, -1, 0, 1'b0, 1'b0);

        run_case(6'd7, 6'd7, -1, 0, 1'b0, 1'b0);

        mem[5] = {2'b00, 6'd3};
        run_case(6'd1, 6'd5, -1, 0, 1'b0, 1'b0);

        mem[5] = {2'b10, 6'd3};
        mem[3] = {2'b10, 6'd5};
        run_case(6'd1, 6'd5, -1, 0, 1'b0, 1'b0);

        load_chain();
        run_case(6'd1, 6'd5, 1, 10, 1'b1, 1'b0);

        // Reset while in ESPERA for the second node.
        @(negedge clk);
        fonte = 6'd1; destino = 6'd5; construir = 1'b1;
        @(posedge clk); #1;
        construir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midwalk_reset", {14'd0, est_rd_en, est_rd_addr, valid, caddr, ultimo, pronto,
                                   erro, ocupado}, 32'd0);
        rst = 1'b0;
        run_case(6'd1, 6'd5, -1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) random_case();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
